// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared types and helpers for the control-word queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int OP_W = 7;

    typedef logic [OP_W-1:0] ctrl_op_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_queue_mem.sv
// ============================================================================
// ctrl_queue_mem : DEPTH x OP_W register array, one write port, async read
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ctrl_queue_mem #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 7,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [OP_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [OP_W-1:0] rdata
);

    logic [OP_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/ctrl_opcode_queue.sv
// ============================================================================
// ctrl_opcode_queue : FWFT control-word queue feeding the control decoder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ctrl_opcode_queue
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OP_W  = ctrl_pkg::OP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_W-1:0]           out_op,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      err_unstable
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_pending;
    logic [OP_W-1:0] r_held_op;
    logic            r_err;
    logic [OP_W-1:0] w_rd_data;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

    assign out_op       = w_empty ? '0 : w_rd_data;
    assign count        = r_count;
    assign err_unstable = r_err;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A stalled offer must be held: same word, valid kept high, until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_held_op <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_pending && (!in_valid || (in_op != r_held_op))) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_pending <= 1'b0;
            end else if (in_valid && !in_ready) begin
                r_pending <= 1'b1;
                r_held_op <= in_op;
            end else if (w_push) begin
                r_pending <= 1'b0;
            end
        end
    end

    ctrl_queue_mem #(
        .DEPTH (DEPTH),
        .OP_W  (OP_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (in_op),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_ctrl_opcode_queue.sv
// ============================================================================
// tb_ctrl_opcode_queue : directed + random bench against a queue-based model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ctrl_opcode_queue;
    import ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = cnt_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [6:0]    out_op;
    logic [CW-1:0] count;
    logic          err_unstable;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue contents as a plain list, plus the
    // stalled-offer tracker for the stability rule.
    bit [6:0] q[$];
    bit       m_err;
    bit       m_pend;
    bit [6:0] m_held;

    always #5 clk = ~clk;

    ctrl_opcode_queue #(.DEPTH(DEPTH), .OP_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .count        (count),
        .err_unstable (err_unstable)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, compare against model, advance model.
    task automatic step(input bit r, input bit f, input bit iv, input bit [6:0] op, input bit ordy);
        bit exp_rdy;
        bit push;
        bit pop;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_op = op; out_ready = ordy;
        #1;
        exp_rdy = (q.size() != DEPTH) && !f;
        if (!r) begin
            check("count",     32'(count),        32'(q.size()));
            check("out_valid", 32'(out_valid),    32'(q.size() != 0));
            check("out_op",    32'(out_op),       (q.size() != 0) ? 32'(q[0]) : 32'd0);
            check("in_ready",  32'(in_ready),     32'(exp_rdy));
            check("err",       32'(err_unstable), 32'(m_err));
        end
        if (r) begin
            q.delete();
            m_err = 1'b0; m_pend = 1'b0; m_held = '0;
        end else begin
            push = iv && exp_rdy;
            pop  = (q.size() != 0) && ordy && !f;
            if (m_pend && (!iv || op != m_held)) m_err = 1'b1;
            if (f) m_pend = 1'b0;
            else if (iv && !exp_rdy) begin m_pend = 1'b1; m_held = op; end
            else if (push) m_pend = 1'b0;
            if (f) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(op);
            end
        end
    endtask

    // Let the edge of the last step land, then look at the registered state.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [6:0] fill[4];
        bit       iv, fl, ordy;
        bit [6:0] op;
        fill = '{7'h15, 7'h2A, 7'h7F, 7'h01};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; out_ready = 1'b0;

        // Reset then idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        settle();
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_op",    32'(out_op), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_err",   32'(err_unstable), 0);
        step(0, 0, 0, 0, 0);

        // Fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, fill[i], 0);
            check("fill_head", 32'(out_op), (i == 0) ? 32'd0 : 32'h15);
        end
        settle();
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(in_ready), 0);
        check("full_head",  32'(out_op), 32'h15);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            check("drain_op", 32'(out_op), 32'(fill[i]));
            if (i == 1) check("reopen_ready", 32'(in_ready), 1);
        end
        settle();
        check("drained_valid", 32'(out_valid), 0);
        check("drained_op",    32'(out_op), 0);

        // Steady push+pop across pointer wrap
        step(0, 0, 1, 7'h00, 0);
        for (int i = 1; i < 10; i++) begin
            step(0, 0, 1, 7'(i), 1);
            check("stream_count", 32'(count), 1);
            check("stream_op",    32'(out_op), 32'(i - 1));
        end
        step(0, 0, 0, 0, 1);
        check("stream_last", 32'(out_op), 32'h09);

        // Flush mid-stream
        step(0, 0, 1, 7'h33, 0);
        step(0, 0, 1, 7'h34, 0);
        step(0, 0, 1, 7'h35, 0);
        settle();
        check("preflush_count", 32'(count), 3);
        check("preflush_head",  32'(out_op), 32'h33);
        step(0, 1, 1, 7'h44, 1);
        settle();
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(out_valid), 0);
        step(0, 0, 1, 7'h55, 0);
        settle();
        check("postflush_op",    32'(out_op), 32'h55);
        check("postflush_count", 32'(count), 1);

        // Randomized traffic obeying the hold rule
        for (int n = 0; n < 400; n++) begin
            fl   = ($urandom_range(15) == 0);
            ordy = ($urandom_range(2) != 0);
            iv   = ($urandom_range(1) != 0);
            op   = 7'($urandom);
            if (m_pend && !fl) begin
                iv = 1'b1;
                op = m_held;
            end
            step(0, fl, iv, op, ordy);
        end

        // Protocol error: change the stalled word
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 7'(i + 1), 0);
        step(0, 0, 1, 7'h10, 0);
        step(0, 0, 1, 7'h11, 0);
        settle();
        check("err_set", 32'(err_unstable), 1);
        step(0, 1, 0, 0, 0);
        settle();
        check("err_thru_flush", 32'(err_unstable), 1);
        step(1, 0, 0, 0, 0);
        settle();
        check("err_cleared", 32'(err_unstable), 0);
        check("err_rst_count", 32'(count), 0);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
